transmissor_serial_a0: RTL and testbench
========================================

// Module: transmissor_serial_a0
// PURPOSE
//  Output end of register a0 (REG[7]) of the 8-bit nRisc datapath: snoops the register-file write
//  port and, each time a0 is written, queues the written byte and ships it on a UART-style serial
//  line (8N1, LSB first). Sits beside the register bank; feeds the board's serial/debug pin.
// PARAMETERS
//  CICLOS_BIT  16  clock cycles per serial bit (>=2)
//  PROF_FIFO   4   FIFO depth in bytes (power of 2, >=2)
//  REG_A0      7   register number treated as a0
// PORTS
//  Clock           in   1  system clock, all logic on posedge
//  Reset           in   1  synchronous, active-low reset
//  EscReg          in   1  register-file write enable (same signal driving the bank)
//  RegEscrito      in   3  register-file write address
//  DadoEscritoReg  in   8  register-file write data
//  Tx              out  1  serial line, idle high, registered
//  Ocupado         out  1  1 while a frame is on the line or FIFO not empty
//  Cheio           out  1  FIFO full
//  Perdido         out  1  sticky: a push was dropped because FIFO was full
//  Ocupacao        out  $clog2(PROF_FIFO)+1  bytes currently queued (excl. byte on the line)
// BEHAVIOUR
//  Reset (Reset==0 at posedge): Tx=1, Ocupado=0, Cheio=0, Perdido=0, Ocupacao=0, FSM=OCIOSO,
//   FIFO pointers and bit/cycle counters cleared. Applies mid-frame: frame aborted, Tx high next edge.
//  Push: posedge with EscReg==1 && RegEscrito==REG_A0 writes DadoEscritoReg into FIFO. Writes to
//   any other register are ignored.
//  FSM: OCIOSO -> INICIO when FIFO not empty (pops head into shift reg, same edge).
//   INICIO: Tx=0 for CICLOS_BIT cycles -> DADOS.
//   DADOS: 8 bits, bit0 first, each CICLOS_BIT cycles -> PARADA.
//   PARADA: Tx=1 for CICLOS_BIT cycles; at end, FIFO not empty -> INICIO (pop, no idle gap),
//   else -> OCIOSO.
//  Frame length exactly 10*CICLOS_BIT cycles. Tx driven from registered state.
//  Latency: push at edge N into empty FIFO with FSM OCIOSO -> pop at edge N+1, Tx falls at N+2 edge
//   output (i.e. visible after edge N+2), Ocupacao goes 1 after N, 0 after N+1.
//  Full: Cheio=1 when Ocupacao==PROF_FIFO. Push while full and no pop that edge: byte dropped,
//   Perdido<=1 (held until reset). Push and pop on same edge while full: push accepted,
//   Ocupacao unchanged, Perdido unchanged.
//  Empty: pop only when Ocupacao>0; push and pop same edge when empty impossible (pop needs
//   Ocupacao>0 before edge).
//  Pointers wrap modulo PROF_FIFO; Ocupacao tracks count independently of wrap.
//  Ocupado = (FSM!=OCIOSO) || (Ocupacao!=0).
// TESTING (bench uses CICLOS_BIT=4, PROF_FIFO=4)
//  Reset then idle 20 cycles -> Tx=1, Ocupado=0, Ocupacao=0, Perdido=0 throughout.
//  Write 8'hA5 to reg 7 -> Tx samples every 4 cycles: 0,1,0,1,0,0,1,0,1,1; frame 40 cycles; Ocupado drops after.
//  Write 8'h3C to reg 3 and reg 0 -> no push, Tx stays 1, Ocupacao=0.
//  Writes 8'h01..8'h06 to reg 7 on consecutive cycles -> 1st goes to line, next 4 queued (Cheio=1),
//   6th dropped, Perdido=1; line carries 01,02,03,04,05 back-to-back with no idle gap, 200 cycles total.
//  Push 8'h12 at the edge the FSM pops while FIFO full -> accepted, Ocupacao stays 4, Perdido stays 0.
//  Reset asserted mid-DADOS of 8'hFF with 2 bytes queued -> next edge Tx=1, Ocupacao=0; nothing sent after release.

Source files
------------

// File: rtl/transmissor_serial_a0.sv
// transmissor_serial_a0: snoops the register-file write port and, whenever
// register a0 is written, queues the byte and sends it as an 8N1 serial frame
// (LSB first, idle high) on Tx.
module transmissor_serial_a0 #(
  parameter int CICLOS_BIT = 16,
  parameter int PROF_FIFO  = 4,
  parameter int REG_A0     = 7
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         EscReg,
  input  logic [2:0]                   RegEscrito,
  input  logic [7:0]                   DadoEscritoReg,
  output logic                         Tx,
  output logic                         Ocupado,
  output logic                         Cheio,
  output logic                         Perdido,
  output logic [$clog2(PROF_FIFO):0]   Ocupacao
);

  localparam int PW = $clog2(PROF_FIFO);
  localparam int CW = $clog2(CICLOS_BIT);

  typedef enum logic [1:0] {OCIOSO, INICIO, DADOS, PARADA} estado_t;

  estado_t         estado;
  logic [7:0]      fila [PROF_FIFO];
  logic [PW-1:0]   ptrEsc;
  logic [PW-1:0]   ptrLei;
  logic [CW-1:0]   contCiclo;
  logic [2:0]      contBit;
  logic [7:0]      deslocador;

  logic fimBit;
  logic escreveA0;
  logic retira;
  logic aceita;
  logic cheioInt;

  // Control decode: last cycle of a bit period, push request, pop and push acceptance.
  // A push into a full FIFO is still accepted when the same edge pops the head.
  always_comb begin
    fimBit    = (contCiclo == CW'(CICLOS_BIT - 1));
    escreveA0 = EscReg && (RegEscrito == 3'(REG_A0));
    cheioInt  = (Ocupacao == (PW + 1)'(PROF_FIFO));
    retira    = (Ocupacao != '0) &&
                ((estado == OCIOSO) || ((estado == PARADA) && fimBit));
    aceita    = escreveA0 && (!cheioInt || retira);
  end

  assign Cheio   = cheioInt;
  assign Ocupado = (estado != OCIOSO) || (Ocupacao != '0);

  // FIFO storage: data only, never reset; writes are suppressed while in reset.
  always_ff @(posedge Clock) begin
    if (Reset && aceita) begin
      fila[ptrEsc] <= DadoEscritoReg;
    end
  end

  // Shift register: loaded with the FIFO head on pop, shifted right after each data bit.
  always_ff @(posedge Clock) begin
    if (retira) begin
      deslocador <= fila[ptrLei];
    end else if ((estado == DADOS) && fimBit) begin
      deslocador <= {1'b0, deslocador[7:1]};
    end
  end

  // Control: FIFO pointers/count, sticky overflow flag, frame FSM and registered Tx.
  // Tx follows the state of the previous cycle, so every frame segment lasts CICLOS_BIT cycles.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      estado    <= OCIOSO;
      Tx        <= 1'b1;
      contCiclo <= '0;
      contBit   <= '0;
      ptrEsc    <= '0;
      ptrLei    <= '0;
      Ocupacao  <= '0;
      Perdido   <= 1'b0;
    end else begin
      case (estado)
        INICIO:  Tx <= 1'b0;
        DADOS:   Tx <= deslocador[0];
        default: Tx <= 1'b1;
      endcase

      if (aceita) ptrEsc <= ptrEsc + 1'b1;
      if (retira) ptrLei <= ptrLei + 1'b1;
      case ({aceita, retira})
        2'b10:   Ocupacao <= Ocupacao + 1'b1;
        2'b01:   Ocupacao <= Ocupacao - 1'b1;
        default: Ocupacao <= Ocupacao;
      endcase
      if (escreveA0 && cheioInt && !retira) Perdido <= 1'b1;

      case (estado)
        OCIOSO: begin
          contCiclo <= '0;
          contBit   <= '0;
          if (retira) estado <= INICIO;
        end
        INICIO: begin
          if (fimBit) begin
            contCiclo <= '0;
            contBit   <= '0;
            estado    <= DADOS;
          end else begin
            contCiclo <= contCiclo + 1'b1;
          end
        end
        DADOS: begin
          if (fimBit) begin
            contCiclo <= '0;
            if (contBit == 3'd7) begin
              contBit <= '0;
              estado  <= PARADA;
            end else begin
              contBit <= contBit + 1'b1;
            end
          end else begin
            contCiclo <= contCiclo + 1'b1;
          end
        end
        PARADA: begin
          if (fimBit) begin
            contCiclo <= '0;
            estado    <= retira ? INICIO : OCIOSO;
          end else begin
            contCiclo <= contCiclo + 1'b1;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_transmissor_serial_a0.sv
// Directed bench for transmissor_serial_a0 with CICLOS_BIT=4, PROF_FIFO=4.
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
module tb_transmissor_serial_a0;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       EscReg;
  logic [2:0] RegEscrito;
  logic [7:0] DadoEscritoReg;
  logic       Tx;
  logic       Ocupado;
  logic       Cheio;
  logic       Perdido;
  logic [2:0] Ocupacao;

  int nChecks = 0;
  int nErr    = 0;

  transmissor_serial_a0 #(
    .CICLOS_BIT(4),
    .PROF_FIFO (4),
    .REG_A0    (7)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .EscReg        (EscReg),
    .RegEscrito    (RegEscrito),
    .DadoEscritoReg(DadoEscritoReg),
    .Tx            (Tx),
    .Ocupado       (Ocupado),
    .Cheio         (Cheio),
    .Perdido       (Perdido),
    .Ocupacao      (Ocupacao)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one set of write-port inputs and advance to the next falling edge.
  task automatic cyc(input logic en, input logic [2:0] r, input logic [7:0] d);
    EscReg         = en;
    RegEscrito     = r;
    DadoEscritoReg = d;
    @(negedge Clock);
  endtask

  task automatic idle();
    cyc(1'b0, 3'd0, 8'h00);
  endtask

  // Bit k (0..9) of an 8N1 frame carrying byte b.
  function automatic logic frameBit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq [5];
    logic [2:0] occAfterPush [6];
    int expOcc;

    seq          = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    occAfterPush = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

    // Reset state and idle line
    Reset = 1'b0;
    idle();
    idle();
    chk("rst_tx", Tx, 1);
    chk("rst_ocupado", Ocupado, 0);
    chk("rst_cheio", Cheio, 0);
    chk("rst_perdido", Perdido, 0);
    chk("rst_ocupacao", Ocupacao, 0);
    Reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle();
      chk("idle_tx", Tx, 1);
      chk("idle_ocupado", Ocupado, 0);
      chk("idle_ocupacao", Ocupacao, 0);
      chk("idle_perdido", Perdido, 0);
    end

    // Single byte 0xA5: queue latency, then 40-cycle frame
    cyc(1'b1, 3'd7, 8'hA5);
    chk("a5_occ_push", Ocupacao, 1);
    chk("a5_ocupado_push", Ocupado, 1);
    chk("a5_tx_push", Tx, 1);
    idle();
    chk("a5_occ_pop", Ocupacao, 0);
    chk("a5_tx_pop", Tx, 1);
    chk("a5_ocupado_pop", Ocupado, 1);
    for (int j = 0; j < 40; j++) begin
      idle();
      chk("a5_tx", Tx, frameBit(8'hA5, j / 4));
      chk("a5_ocupado", Ocupado, (j < 39) ? 1 : 0);
    end
    idle();
    chk("a5_tx_after", Tx, 1);
    chk("a5_ocupado_after", Ocupado, 0);

    // Writes to other registers are ignored
    cyc(1'b1, 3'd3, 8'h3C);
    chk("r3_occ", Ocupacao, 0);
    chk("r3_tx", Tx, 1);
    cyc(1'b1, 3'd0, 8'h3C);
    chk("r0_occ", Ocupacao, 0);
    chk("r0_tx", Tx, 1);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("other_tx", Tx, 1);
      chk("other_ocupado", Ocupado, 0);
    end

    // Burst 01..06: four queued, sixth dropped, five frames back-to-back
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 3'd7, 8'(i + 1));
      chk("burst_occ", Ocupacao, occAfterPush[i]);
      chk("burst_cheio", Cheio, (i >= 4) ? 1 : 0);
      chk("burst_perdido", Perdido, (i == 5) ? 1 : 0);
      chk("burst_tx", Tx, (i < 2) ? 1'b1 : frameBit(8'h01, (i - 2) / 4));
    end
    for (int j = 4; j < 200; j++) begin
      idle();
      expOcc = 4 - ((j >= 39) ? 1 : 0) - ((j >= 79) ? 1 : 0)
                 - ((j >= 119) ? 1 : 0) - ((j >= 159) ? 1 : 0);
      chk("burst_line_tx", Tx, frameBit(seq[j / 40], (j % 40) / 4));
      chk("burst_line_occ", Ocupacao, expOcc);
      chk("burst_line_ocupado", Ocupado, (j < 199) ? 1 : 0);
    end
    chk("burst_perdido_held", Perdido, 1);
    idle();
    chk("burst_tx_after", Tx, 1);

    // Push on the edge that pops while full: accepted, no loss
    Reset = 1'b0;
    idle();
    Reset = 1'b1;
    idle();
    chk("full_rst_perdido", Perdido, 0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 3'd7, 8'(i + 1));
    chk("full_occ", Ocupacao, 4);
    chk("full_cheio", Cheio, 1);
    for (int j = 3; j <= 38; j++) idle();
    chk("full_occ_before_pop", Ocupacao, 4);
    cyc(1'b1, 3'd7, 8'h12);
    chk("pushpop_occ", Ocupacao, 4);
    chk("pushpop_cheio", Cheio, 1);
    chk("pushpop_perdido", Perdido, 0);
    idle();
    chk("pushpop_occ_next", Ocupacao, 4);

    // Reset in the middle of a frame with bytes queued
    Reset = 1'b0;
    idle();
    Reset = 1'b1;
    idle();
    cyc(1'b1, 3'd7, 8'hFF);
    cyc(1'b1, 3'd7, 8'hAA);
    cyc(1'b1, 3'd7, 8'hBB);
    chk("abort_occ", Ocupacao, 2);
    chk("abort_start", Tx, 0);
    repeat (10) idle();
    chk("abort_mid_tx", Tx, 1);
    chk("abort_mid_ocupado", Ocupado, 1);
    Reset = 1'b0;
    idle();
    chk("abort_tx", Tx, 1);
    chk("abort_occ_rst", Ocupacao, 0);
    chk("abort_ocupado", Ocupado, 0);
    chk("abort_cheio", Cheio, 0);
    Reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      idle();
      chk("post_abort_tx", Tx, 1);
      chk("post_abort_ocupado", Ocupado, 0);
    end

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
